ahb_sramc_slave_gen2: RTL and testbench
=======================================

Name: ahb_sramc_slave_gen2

Overview:
Parametrised AHB-Lite slave front end for the multi-bank SRAM controller. It replaces the zero-wait, fixed-geometry slave. Data width, bank count and bank depth are generalised, reads take a programmable number of wait states, and it adds an AHB ERROR response for illegal transfers. It also resolves the single-port conflict between a write data phase and a following read address phase by stalling. It sits between the AHB interconnect and the NUM_BANKS x LANES array of byte-wide synchronous SRAMs.

Parameters:
DATA_WIDTH, 32, AHB data width; 32 or 64. LANES = DATA_WIDTH/8 byte-wide SRAMs per bank.
NUM_BANKS, 2, number of banks; power of 2, 1..8.
BANK_ADDR_WIDTH, 13, word-address width of each SRAM.
WAIT_STATES, 0, extra read data-phase cycles; 0..3.

Ports:
hclk  in  1  AHB clock
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  32  byte address
htrans  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
hwrite  in  1  1=write
hsize  in  3  transfer size, log2 bytes
hburst  in  3  burst type; informational only, not decoded
hready  in  1  bus-level ready
hwdata  in  DATA_WIDTH  write data
hrdata  out  DATA_WIDTH  read data
hready_resp  out  1  slave ready
hresp  out  2  00 OKAY, 01 ERROR
sram_addr  out  BANK_ADDR_WIDTH  word address, shared by all SRAMs
sram_wdata  out  DATA_WIDTH  write data, lane k feeds SRAM lane k
sram_we  out  1  write enable
sram_cs  out  NUM_BANKS*LANES  chip select, bit b*LANES+k = bank b lane k
sram_rdata  in  NUM_BANKS*DATA_WIDTH  registered SRAM outputs, one cycle after cs with we=0

Behaviour:
- Single clock hclk. Reset is asynchronous, active-low on hresetn.
- Reset values: hready_resp=1, hresp=00, hrdata=0, sram_cs=0, sram_we=0, sram_addr=0, FSM=IDLE.
- Reset mid-transfer: outputs go to reset values immediately. A pending write or read is dropped.
- Accept: hsel && hready && htrans[1]. IDLE/BUSY, or hsel=0: OKAY, zero wait, no SRAM access.
- Decode: OFS=log2(LANES).
  - Byte offset = haddr[OFS-1:0].
  - word = haddr[OFS+BANK_ADDR_WIDTH-1:OFS].
  - bank = the next log2(NUM_BANKS) bits.
- Lane mask: 2^hsize consecutive lanes starting at the byte offset.
- Illegal transfer (-> ERROR) if any of:
  - hsize > OFS;
  - haddr not aligned to 2^hsize;
  - haddr >= NUM_BANKS*LANES*2^BANK_ADDR_WIDTH.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE, ERR1, ERR2.
- Write: address phase registers word, bank and lane mask -> WR. WR is the data phase and lasts 1 cycle:
  - sram_we=1, sram_cs = mask at the selected bank, sram_addr = registered word, sram_wdata = hwdata;
  - hready_resp=1, hresp=00.
- Read, normal case: SRAM is driven combinationally in the address phase (cs = mask, we=0, addr from haddr).
  - Next state: RD_WAIT if WAIT_STATES>0, else RD_DONE.
  - RD_WAIT holds hready_resp=0 for WAIT_STATES cycles and captures the selected bank's sram_rdata on its first cycle.
- Read during WR: a read accepted while in WR cannot use the SRAM that cycle. The address is stored, FSM -> RD_ISSUE.
  - RD_ISSUE: cs/addr driven from the stored address, hready_resp=0.
  - Then RD_WAIT / RD_DONE as in the normal case. Net cost is one extra wait.
- RD_DONE: hrdata = captured or live bank data, full width, unused lanes unmasked; hready_resp=1, hresp=00.
- hrdata holds its last value outside RD_DONE.
- Pipelining: a new transfer may be accepted in WR or RD_DONE, when hready_resp=1.
- Error, two-cycle response, no SRAM access:
  - ERR1: hresp=01, hready_resp=0.
  - ERR2: hresp=01, hready_resp=1.
  - A transfer accepted in ERR2 is processed normally.
- Write latency is always 0 wait states. Read latency is WAIT_STATES + (1 if following WR).

Test Plan:
Parameters for all scenarios: DATA_WIDTH=32, NUM_BANKS=2, BANK_ADDR_WIDTH=13, capacity 0x10000.
1. Word write haddr=0x4, hwdata=0xDEADBEEF -> data phase sram_we=1, sram_cs=0x0F, sram_addr=1. An IDLE cycle, then a read of 0x4 -> hrdata=0xDEADBEEF with hready_resp=1 in the first data cycle.
2. Byte write haddr=0x8003, hsize=0, hwdata=0xAB000000 -> sram_cs=0x80, sram_addr=0. Read back 0x8000 word -> byte3=0xAB.
3. Back-to-back write 0x10=0x12345678 then read 0x10 -> read data phase has hready_resp=0 for exactly 1 cycle, then hrdata=0x12345678.
4. Halfword haddr=0x1 -> hresp=01/hready_resp=0, then hresp=01/hready_resp=1, sram_cs=0 throughout. Same response for a word access at haddr=0x10000 and for hsize=3.
5. WAIT_STATES=2, read of a prewritten word -> hready_resp low exactly 2 cycles, correct data on the 3rd data cycle. A following write stays zero-wait.
6. hresetn asserted in RD_WAIT -> same cycle hready_resp=1, hresp=00, sram_cs=0. After release, an IDLE transfer gets OKAY with zero wait.

Source files
------------

// File: rtl/ahb_sramc_slave_gen2.sv
// AHB-Lite slave front end for a NUM_BANKS x LANES array of byte-wide synchronous SRAMs.
// Programmable read wait states, ERROR response for illegal transfers, write/read port-conflict stall.
module ahb_sramc_slave_gen2 #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_BANKS       = 2,
  parameter int BANK_ADDR_WIDTH = 13,
  parameter int WAIT_STATES     = 0
) (
  input  logic                                   hclk_i,
  input  logic                                   hresetn_i,
  input  logic                                   hsel_i,
  input  logic [31:0]                            haddr_i,
  input  logic [1:0]                             htrans_i,
  input  logic                                   hwrite_i,
  input  logic [2:0]                             hsize_i,
  input  logic [2:0]                             hburst_i,
  input  logic                                   hready_i,
  input  logic [DATA_WIDTH-1:0]                  hwdata_i,
  output logic [DATA_WIDTH-1:0]                  hrdata_o,
  output logic                                   hready_resp_o,
  output logic [1:0]                             hresp_o,
  output logic [BANK_ADDR_WIDTH-1:0]             sram_addr_o,
  output logic [DATA_WIDTH-1:0]                  sram_wdata_o,
  output logic                                   sram_we_o,
  output logic [NUM_BANKS*(DATA_WIDTH/8)-1:0]    sram_cs_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]        sram_rdata_i
);

  localparam int LANES    = DATA_WIDTH / 8;
  localparam int OFS      = $clog2(LANES);
  localparam int BW       = $clog2(NUM_BANKS);
  localparam int BW_W     = (BW > 0) ? BW : 1;
  localparam int CSW      = NUM_BANKS * LANES;
  localparam int CAP_BITS = OFS + BANK_ADDR_WIDTH + BW;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_RD_ISSUE, ST_RD_WAIT, ST_RD_DONE, ST_ERR1, ST_ERR2
  } state_e;

  state_e                     state_q;
  logic [BANK_ADDR_WIDTH-1:0] word_q;
  logic [BW_W-1:0]            bank_q;
  logic [LANES-1:0]           mask_q;
  logic [1:0]                 wcnt_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic [DATA_WIDTH-1:0]      hrdata_q;

  logic [BANK_ADDR_WIDTH-1:0] word_d;
  logic [BW_W-1:0]            bank_d;
  logic [LANES-1:0]           mask_d;
  logic                       illegal_d;
  logic [7:0]                 size_bytes_s;
  logic [2:0]                 align_s;
  logic                       hready_s;
  logic                       accept_s;
  state_e                     next_s;
  logic [DATA_WIDTH-1:0]      rd_sel_s;
  logic [DATA_WIDTH-1:0]      rd_data_s;
  logic                       unused_s;

  assign unused_s = ^{hburst_i, htrans_i[0]};

  // Address-phase decode: word, bank, lane mask and legality.
  always_comb begin
    word_d = haddr_i[OFS +: BANK_ADDR_WIDTH];
    bank_d = BW_W'((haddr_i >> (OFS + BANK_ADDR_WIDTH)) & 32'(NUM_BANKS - 1));
    case (hsize_i)
      3'd0:    begin size_bytes_s = 8'h01; align_s = 3'd0; end
      3'd1:    begin size_bytes_s = 8'h03; align_s = 3'd1; end
      3'd2:    begin size_bytes_s = 8'h0F; align_s = 3'd3; end
      3'd3:    begin size_bytes_s = 8'hFF; align_s = 3'd7; end
      default: begin size_bytes_s = 8'hFF; align_s = 3'd7; end
    endcase
    mask_d    = LANES'({8'h00, size_bytes_s} << haddr_i[OFS-1:0]);
    illegal_d = (hsize_i > 3'(OFS)) ||
                ((haddr_i[2:0] & align_s) != 3'd0) ||
                ((haddr_i >> CAP_BITS) != 32'd0);
  end

  // Ready decode, transfer acceptance and the next state for an accepting state.
  always_comb begin
    case (state_q)
      ST_RD_ISSUE, ST_RD_WAIT, ST_ERR1: hready_s = 1'b0;
      default:                          hready_s = 1'b1;
    endcase
    accept_s = hresetn_i && hsel_i && hready_i && htrans_i[1] && hready_s;
    if (!accept_s) begin
      next_s = ST_IDLE;
    end else if (illegal_d) begin
      next_s = ST_ERR1;
    end else if (hwrite_i) begin
      next_s = ST_WR;
    end else if (state_q == ST_WR) begin
      // SRAM port is busy with the write data phase this cycle
      next_s = ST_RD_ISSUE;
    end else if (WAIT_STATES > 0) begin
      next_s = ST_RD_WAIT;
    end else begin
      next_s = ST_RD_DONE;
    end
  end

  // SRAM port drive: write data phase, deferred read issue, or a live read address phase.
  always_comb begin
    sram_cs_o    = '0;
    sram_we_o    = 1'b0;
    sram_addr_o  = word_q;
    sram_wdata_o = hwdata_i;
    if (state_q == ST_WR) begin
      sram_we_o = 1'b1;
      sram_cs_o = CSW'(mask_q) << (bank_q * LANES);
    end else if (state_q == ST_RD_ISSUE) begin
      sram_cs_o = CSW'(mask_q) << (bank_q * LANES);
    end else if (accept_s && !illegal_d && !hwrite_i) begin
      sram_cs_o   = CSW'(mask_d) << (bank_d * LANES);
      sram_addr_o = word_d;
    end else begin
      sram_cs_o = '0;
    end
  end

  assign rd_sel_s  = sram_rdata_i[bank_q*DATA_WIDTH +: DATA_WIDTH];
  assign rd_data_s = (WAIT_STATES == 0) ? rd_sel_s : rdata_q;

  // Bus response outputs decoded from the state register.
  always_comb begin
    hready_resp_o = hready_s;
    hresp_o       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    hrdata_o      = (state_q == ST_RD_DONE) ? rd_data_s : hrdata_q;
  end

  // Transfer FSM with captured address/mask, wait counter and read data registers.
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      bank_q   <= '0;
      mask_q   <= '0;
      wcnt_q   <= 2'd0;
      rdata_q  <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept_s) begin
        word_q <= word_d;
        bank_q <= bank_d;
        mask_q <= mask_d;
      end
      case (state_q)
        ST_RD_ISSUE: begin
          state_q <= (WAIT_STATES > 0) ? ST_RD_WAIT : ST_RD_DONE;
          wcnt_q  <= 2'd0;
        end
        ST_RD_WAIT: begin
          if (wcnt_q == 2'd0) begin
            rdata_q <= rd_sel_s;
          end
          if (wcnt_q == 2'(WAIT_STATES - 1)) begin
            state_q <= ST_RD_DONE;
          end else begin
            wcnt_q <= wcnt_q + 2'd1;
          end
        end
        ST_RD_DONE: begin
          hrdata_q <= rd_data_s;
          state_q  <= next_s;
          wcnt_q   <= 2'd0;
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
        end
        default: begin
          state_q <= next_s;
          wcnt_q  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sramc_slave_gen2.sv
// Directed bench: one slave with zero read wait states and one with two, each on its own SRAM model.
module tb_ahb_sramc_slave_gen2;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic [31:0] hrdata0, hrdata2, wdata0, wdata2;
  logic        hready0, hready2, we0, we2;
  logic [1:0]  hresp0, hresp2;
  logic [12:0] addr0, addr2;
  logic [7:0]  cs0, cs2;
  logic [63:0] rdata0, rdata2;

  logic [7:0]  mem0 [8][8192];
  logic [7:0]  mem2 [8][8192];

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic [31:0] e_addr [3] = '{32'h0000_0001, 32'h0001_0000, 32'h0000_0000};
  logic [2:0]  e_size [3] = '{3'd1, 3'd2, 3'd3};

  always #5 hclk = ~hclk;

  ahb_sramc_slave_gen2 #(.DATA_WIDTH(32), .NUM_BANKS(2), .BANK_ADDR_WIDTH(13), .WAIT_STATES(0)) u_dut0 (
    .hclk_i(hclk), .hresetn_i(hresetn), .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hready_i(hready0), .hwdata_i(hwdata),
    .hrdata_o(hrdata0), .hready_resp_o(hready0), .hresp_o(hresp0), .sram_addr_o(addr0),
    .sram_wdata_o(wdata0), .sram_we_o(we0), .sram_cs_o(cs0), .sram_rdata_i(rdata0)
  );

  ahb_sramc_slave_gen2 #(.DATA_WIDTH(32), .NUM_BANKS(2), .BANK_ADDR_WIDTH(13), .WAIT_STATES(2)) u_dut2 (
    .hclk_i(hclk), .hresetn_i(hresetn), .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hready_i(hready2), .hwdata_i(hwdata),
    .hrdata_o(hrdata2), .hready_resp_o(hready2), .hresp_o(hresp2), .sram_addr_o(addr2),
    .sram_wdata_o(wdata2), .sram_we_o(we2), .sram_cs_o(cs2), .sram_rdata_i(rdata2)
  );

  // Byte-wide synchronous SRAM models; chip-select bit k lands on read-data byte k.
  always @(posedge hclk) begin
    for (int k = 0; k < 8; k++) begin
      if (cs0[k]) begin
        if (we0) mem0[k][addr0] <= wdata0[(k%4)*8 +: 8];
        else     rdata0[k*8 +: 8] <= mem0[k][addr0];
      end
      if (cs2[k]) begin
        if (we2) mem2[k][addr2] <= wdata2[(k%4)*8 +: 8];
        else     rdata2[k*8 +: 8] <= mem2[k][addr2];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [1:0] tr, input logic wr, input logic [2:0] sz);
    hsel   = 1'b1;
    haddr  = a;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic mid();
    @(negedge hclk);
  endtask

  initial begin
    hresetn = 1'b0;
    hwdata  = 32'h0;
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("rst_hready", 64'(hready0), 64'd1);
    chk("rst_hresp",  64'(hresp0),  64'd0);
    chk("rst_hrdata", 64'(hrdata0), 64'd0);
    chk("rst_cs",     64'(cs0),     64'd0);
    chk("rst_we",     64'(we0),     64'd0);
    chk("rst_addr",   64'(addr0),   64'd0);
    tick();
    hresetn = 1'b1;

    // 1: word write 0x4, idle, read back
    bus(32'h4, NONSEQ, 1'b1, 3'd2);
    mid();
    chk("t1_waddr_cs", 64'(cs0), 64'd0);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    hwdata = 32'hDEAD_BEEF;
    mid();
    chk("t1_we",     64'(we0),     64'd1);
    chk("t1_cs",     64'(cs0),     64'h0F);
    chk("t1_addr",   64'(addr0),   64'd1);
    chk("t1_wdata",  64'(wdata0),  64'hDEAD_BEEF);
    chk("t1_wready", 64'(hready0), 64'd1);
    tick();
    mid();
    chk("t1_idle_ready", 64'(hready0), 64'd1);
    chk("t1_idle_cs",    64'(cs0),     64'd0);
    tick();
    bus(32'h4, NONSEQ, 1'b0, 3'd2);
    mid();
    chk("t1_rcs",   64'(cs0),   64'h0F);
    chk("t1_rwe",   64'(we0),   64'd0);
    chk("t1_raddr", 64'(addr0), 64'd1);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t1_rready", 64'(hready0), 64'd1);
    chk("t1_rdata",  64'(hrdata0), 64'hDEAD_BEEF);

    // 2: byte write to bank 1 lane 3, word read back
    tick();
    bus(32'h8003, NONSEQ, 1'b1, 3'd0);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    hwdata = 32'hAB00_0000;
    mid();
    chk("t2_cs",   64'(cs0),   64'h80);
    chk("t2_addr", 64'(addr0), 64'd0);
    chk("t2_we",   64'(we0),   64'd1);
    tick();
    bus(32'h8000, NONSEQ, 1'b0, 3'd2);
    mid();
    chk("t2_rcs", 64'(cs0), 64'hF0);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t2_byte3", 64'(hrdata0[31:24]), 64'hAB);

    // 3: write then read back-to-back costs one stall cycle
    tick();
    bus(32'h10, NONSEQ, 1'b1, 3'd2);
    tick();
    bus(32'h10, NONSEQ, 1'b0, 3'd2);
    hwdata = 32'h1234_5678;
    mid();
    chk("t3_we",     64'(we0),     64'd1);
    chk("t3_cs",     64'(cs0),     64'h0F);
    chk("t3_addr",   64'(addr0),   64'd4);
    chk("t3_wready", 64'(hready0), 64'd1);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t3_stall_ready", 64'(hready0), 64'd0);
    chk("t3_issue_cs",    64'(cs0),     64'h0F);
    chk("t3_issue_we",    64'(we0),     64'd0);
    chk("t3_issue_addr",  64'(addr0),   64'd4);
    tick();
    mid();
    chk("t3_rready", 64'(hready0), 64'd1);
    chk("t3_rdata",  64'(hrdata0), 64'h1234_5678);

    // 4: illegal transfers get a two-cycle ERROR with no SRAM access
    for (int i = 0; i < 3; i++) begin
      tick();
      bus(e_addr[i], NONSEQ, 1'b0, e_size[i]);
      mid();
      chk("t4_aphase_cs", 64'(cs0), 64'd0);
      tick();
      bus(32'h0, IDLE, 1'b0, 3'd2);
      mid();
      chk("t4_err1_resp",  64'(hresp0),  64'd1);
      chk("t4_err1_ready", 64'(hready0), 64'd0);
      chk("t4_err1_cs",    64'(cs0),     64'd0);
      tick();
      mid();
      chk("t4_err2_resp",  64'(hresp0),  64'd1);
      chk("t4_err2_ready", 64'(hready0), 64'd1);
      chk("t4_err2_cs",    64'(cs0),     64'd0);
    end
    // misaligned word, then a read accepted during ERR2
    tick();
    bus(32'h2, NONSEQ, 1'b0, 3'd2);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t4b_err1_resp", 64'(hresp0), 64'd1);
    tick();
    bus(32'h10, NONSEQ, 1'b0, 3'd2);
    mid();
    chk("t4b_err2_resp",  64'(hresp0),  64'd1);
    chk("t4b_err2_ready", 64'(hready0), 64'd1);
    chk("t4b_err2_rcs",   64'(cs0),     64'h0F);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t4b_resp",  64'(hresp0),  64'd0);
    chk("t4b_rdata", 64'(hrdata0), 64'h1234_5678);

    // 5: two read wait states on the second slave
    for (int i = 0; i < 6; i++) tick();
    bus(32'h20, NONSEQ, 1'b1, 3'd2);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    hwdata = 32'hCAFE_F00D;
    mid();
    chk("t5_we",     64'(we2),     64'd1);
    chk("t5_cs",     64'(cs2),     64'h0F);
    chk("t5_addr",   64'(addr2),   64'd8);
    chk("t5_wready", 64'(hready2), 64'd1);
    tick();
    bus(32'h20, NONSEQ, 1'b0, 3'd2);
    mid();
    chk("t5_rcs", 64'(cs2), 64'h0F);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t5_wait1", 64'(hready2), 64'd0);
    tick();
    mid();
    chk("t5_wait2", 64'(hready2), 64'd0);
    tick();
    bus(32'h24, NONSEQ, 1'b1, 3'd2);
    mid();
    chk("t5_rready", 64'(hready2), 64'd1);
    chk("t5_rdata",  64'(hrdata2), 64'hCAFE_F00D);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    hwdata = 32'h0BAD_F00D;
    mid();
    chk("t5_w2_ready", 64'(hready2), 64'd1);
    chk("t5_w2_we",    64'(we2),     64'd1);
    chk("t5_w2_addr",  64'(addr2),   64'd9);
    chk("t5_hold",     64'(hrdata2), 64'hCAFE_F00D);

    // 6: reset asserted while in RD_WAIT
    tick();
    bus(32'h20, NONSEQ, 1'b0, 3'd2);
    tick();
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t6_in_wait", 64'(hready2), 64'd0);
    #1;
    hresetn = 1'b0;
    #1;
    chk("t6_rst_ready",  64'(hready2), 64'd1);
    chk("t6_rst_resp",   64'(hresp2),  64'd0);
    chk("t6_rst_cs",     64'(cs2),     64'd0);
    chk("t6_rst_hrdata", 64'(hrdata2), 64'd0);
    tick();
    hresetn = 1'b1;
    bus(32'h0, IDLE, 1'b0, 3'd2);
    mid();
    chk("t6_idle_ready", 64'(hready2), 64'd1);
    chk("t6_idle_resp",  64'(hresp2),  64'd0);
    chk("t6_idle_cs",    64'(cs2),     64'd0);
    tick();
    mid();
    chk("t6_idle_ready2", 64'(hready2), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
